// File: rtl/oam_dma_controller_if.sv
// ---------------------------------------------------------------------------
// oam_dma_controller_if
// Bus bundle between the CPU core, the OAM DMA controller and the
// processor memory interface.
//
// Signals:
//   cpu_address/cpu_read/cpu_write/cpu_write_data : CPU core request
//                                                    (strobes active low)
//   mem_read_data       : byte returned by the memory interface
//   mem_address/mem_read/mem_write/mem_write_data : request forwarded to the
//                                                    memory interface
//   cpu_halt            : 1 = CPU core must stall (RDY low)
//   OAMDMA_reg          : last page written to $4014
//   OAMDMA_reg_active   : per-bit driven mask for $4014 reads
//
// Modports:
//   master : the DMA controller (drives the memory side and the halt)
//   slave  : the surrounding system (CPU core + memory interface)
// ---------------------------------------------------------------------------
interface oam_dma_controller_if;
    logic [15:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_write_data;
    logic [7:0]  mem_read_data;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_write_data;
    logic        cpu_halt;
    logic [7:0]  OAMDMA_reg;
    logic [7:0]  OAMDMA_reg_active;

    modport master (
        input  cpu_address, cpu_read, cpu_write, cpu_write_data, mem_read_data,
        output mem_address, mem_read, mem_write, mem_write_data,
               cpu_halt, OAMDMA_reg, OAMDMA_reg_active
    );

    modport slave (
        output cpu_address, cpu_read, cpu_write, cpu_write_data, mem_read_data,
        input  mem_address, mem_read, mem_write, mem_write_data,
               cpu_halt, OAMDMA_reg, OAMDMA_reg_active
    );
endinterface

// File: rtl/oam_dma_controller.sv
// ---------------------------------------------------------------------------
// oam_dma_controller
// Sits between the CPU core and the memory interface. A CPU write to
// DMA_REG_ADDR halts the CPU and copies one page (XFER_BYTES bytes) from
// {page, index} to OAMDATA_ADDR, one read cycle plus one write cycle per
// byte. When idle the CPU request is passed straight through.
//
// Ports:
//   cpu_clock : system clock, all state updates on posedge
//   reset_n   : asynchronous active-low reset
//   bus       : oam_dma_controller_if.master (CPU side in, memory side out,
//               cpu_halt, OAMDMA_reg, OAMDMA_reg_active)
//
// Optional feature macro: OAM_DMA_READBACK_EN
//   defined   -> OAMDMA_reg_active = 8'hFF ($4014 reads return the page)
//   undefined -> OAMDMA_reg_active = 8'h00 (open bus on $4014 reads)
// ---------------------------------------------------------------------------
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
    parameter int          XFER_BYTES   = 256
) (
    input  logic                  cpu_clock,
    input  logic                  reset_n,
    oam_dma_controller_if.master  bus
);

    localparam logic [7:0] LAST_INDEX = 8'(XFER_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       parity;
    logic [7:0] index;
    logic [7:0] data_latch;
    logic [7:0] page;
    logic       trigger;

    assign trigger = !bus.cpu_write && (bus.cpu_address == DMA_REG_ADDR);

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            parity     <= 1'b0;
            index      <= 8'h00;
            data_latch <= 8'h00;
            page       <= 8'h00;
        end else begin
            state  <= state_next;
            // Free-running cycle parity; decides whether an ALIGN cycle is
            // needed so that reads always land on the same parity.
            parity <= ~parity;
            if (state == IDLE && trigger) begin
                page <= bus.cpu_write_data;
            end
            if (state == READ) begin
                data_latch <= bus.mem_read_data;
            end
            if (state == WRITE) begin
                index <= (index == LAST_INDEX) ? 8'h00 : index + 8'h01;
            end
        end
    end

    always_comb begin
        // Non-IDLE default: halted CPU, both strobes inactive.
        state_next         = state;
        bus.cpu_halt       = 1'b1;
        bus.mem_address    = {page, index};
        bus.mem_read       = 1'b1;
        bus.mem_write      = 1'b1;
        bus.mem_write_data = data_latch;

        case (state)
            IDLE: begin
                // Pass-through; the triggering $4014 write also goes out.
                bus.cpu_halt       = 1'b0;
                bus.mem_address    = bus.cpu_address;
                bus.mem_read       = bus.cpu_read;
                bus.mem_write      = bus.cpu_write;
                bus.mem_write_data = bus.cpu_write_data;
                if (trigger) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                state_next = parity ? ALIGN : READ;
            end
            ALIGN: begin
                state_next = READ;
            end
            READ: begin
                bus.mem_read = 1'b0;
                state_next   = WRITE;
            end
            WRITE: begin
                bus.mem_address = OAMDATA_ADDR;
                bus.mem_write   = 1'b0;
                state_next      = (index == LAST_INDEX) ? IDLE : READ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.OAMDMA_reg = page;

`ifdef OAM_DMA_READBACK_EN
    assign bus.OAMDMA_reg_active = 8'hFF;
`else
    assign bus.OAMDMA_reg_active = 8'h00;
`endif

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sits between the CPU core and processor_memory_interface.
- Decodes CPU writes to $4014 and halts the CPU. It then copies one 256-byte page of CPU address space to PPU OAMDATA ($2004) by driving the memory interface's address/read/write inputs itself.
- Also sources the OAMDMA_reg and OAMDMA_reg_active values that the memory interface presents on reads of $4014.
- When idle, it passes CPU bus requests through unchanged.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAMDATA_ADDR, 16'h2004, destination address written for each byte.
- XFER_BYTES, 256, bytes per transfer. Must be a power of two ≤ 256.

Ports:
- cpu_clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- cpu_address  input  16  CPU core address.
- cpu_read  input  1  CPU read strobe, active low.
- cpu_write  input  1  CPU write strobe, active low.
- cpu_write_data  input  8  data the CPU is writing.
- mem_read_data  input  8  byte returned by the memory interface for the current read.
- mem_address  output  16  address to the memory interface.
- mem_read  output  1  read strobe to the memory interface, active low.
- mem_write  output  1  write strobe to the memory interface, active low.
- mem_write_data  output  8  write data to the memory interface.
- cpu_halt  output  1  1 = CPU core must stall (RDY low).
- OAMDMA_reg  output  8  last page written to $4014.
- OAMDMA_reg_active  output  8  per-bit driven mask for $4014 reads.

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE, cpu_halt=0, OAMDMA_reg=8'h00, byte index=0, latched byte=8'h00, parity=0.
  - Outputs immediately revert to IDLE pass-through.
- Parity flop toggles every posedge cpu_clock; the first cycle after reset release is even (parity=0).
- IDLE outputs, combinational pass-through:
  - mem_address=cpu_address, mem_read=cpu_read, mem_write=cpu_write, mem_write_data=cpu_write_data.
- Trigger: in IDLE, cpu_write=0 && cpu_address==DMA_REG_ADDR at a posedge:
  - OAMDMA_reg<=cpu_write_data.
  - State<=HALT.
  - The triggering write is still passed through that cycle.
- States:
  - HALT: cpu_halt=1, mem_read=mem_write=1 (idle bus). Next state is ALIGN if parity=1 this cycle, otherwise READ.
  - ALIGN: cpu_halt=1, idle bus. Lasts one cycle, then READ.
  - READ: mem_address={OAMDMA_reg, index[7:0]}, mem_read=0, mem_write=1. mem_read_data is latched at the posedge ending the cycle. Next state WRITE.
  - WRITE: mem_address=OAMDATA_ADDR, mem_write=0, mem_read=1, mem_write_data=latched byte. Index increments. If index was XFER_BYTES-1, go to IDLE with index<=0; otherwise go to READ.
- Outputs are registered or derived from state only (except the IDLE pass-through), so they are stable before the memory interface's negedge sample.
- cpu_halt is 1 in every non-IDLE state and drops in the cycle after the last WRITE.
- Total halt length is 1+2*XFER_BYTES cycles: 513 when the HALT cycle is even, 514 when it is odd.
- Index is 8 bits and wraps 8'hFF->8'h00; the source address never crosses the page.
- CPU strobes are ignored while not IDLE, including a second $4014 write: no retrigger and OAMDMA_reg is unchanged.
- Page $20–$3F sources are not special-cased; the bus contract is identical for every page.
- Reset mid-transfer aborts immediately. No further OAM writes occur and the next trigger restarts from index 0.
- OAMDMA_reg_active=8'h00 (write-only register, open bus on read), unless the optional feature is enabled.

Optional Feature:
- Macro: OAM_DMA_READBACK_EN.
- Defined: OAMDMA_reg_active=8'hFF, so CPU reads of $4014 return the last written page. Used for debug/bring-up.
- Undefined: OAMDMA_reg_active=8'h00, giving true open-bus behaviour.

Test Plan:
- Reset: hold reset_n=0 mid-sim -> cpu_halt=0, OAMDMA_reg=8'h00, outputs equal the CPU inputs. Drive cpu_address=16'h0123, cpu_read=0 -> mem_address=16'h0123, mem_read=0.
- Even-parity DMA: write 8'h02 to $4014 so that HALT lands on an even cycle, with a memory model returning addr[7:0]^8'h5A -> cpu_halt high exactly 513 cycles. Expect 256 writes to $2004 with data i^8'h5A for source 16'h0200+i, in order.
- Odd-parity DMA: same stimulus shifted one cycle -> 514 halt cycles, one ALIGN cycle with both strobes high, data sequence identical.
- Ignore during DMA: CPU asserts cpu_write=0 at $4014 with data 8'h07 mid-transfer -> no retrigger, OAMDMA_reg stays 8'h02, total still 513/514 cycles.
- Abort: assert reset_n=0 after 100 OAM writes -> cpu_halt=0 immediately, no further $2004 writes. A new trigger of 8'h03 then copies from 16'h0300 starting at index 0.
- Readback: with OAM_DMA_READBACK_EN, after writing 8'h02 -> OAMDMA_reg_active=8'hFF and OAMDMA_reg=8'h02. Without the macro -> active=8'h00.
